// File: rtl/fsm_ctrl_pkg.sv
// Shared FSM state encoding and sizing helper for the count arbiter.
package fsm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Index width for n items; never less than one bit.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter_pick
    import fsm_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [IDX_W:0] slot;
    logic           found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        slot  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (slot >= (IDX_W + 1)'(N_REQ)) begin
                slot = slot - (IDX_W + 1)'(N_REQ);
            end
            if (!found && req[slot[IDX_W-1:0]]) begin
                pick[slot[IDX_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fsm_count_arbiter.sv
// Round-robin arbiter sharing one 0..TERM counter among N_REQ requesters.
module fsm_count_arbiter
    import fsm_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned      IDX_W  = clog2_f(N_REQ);
    localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] next_ptr;
    logic [N_REQ-1:0] gnt_d, done_d;
    logic             busy_d;

    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // One-hot pick to binary index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign next_ptr = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

    // Next state; outputs are precomputed from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                end else if (cnt_q == TERM_V) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        gnt_d  = busy_d ? (N_REQ'(1) << idx_d) : '0;
        done_d = (state_d == ST_DONE) ? (N_REQ'(1) << idx_d) : '0;
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_fsm_count_arbiter.sv
// Self-checking bench: job-level reference model plus directed timing scenarios.
module tb_fsm_count_arbiter;

    localparam int N    = 4;
    localparam int TERM = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt, done;
    logic       busy;
    logic [3:0] cnt;

    logic [3:0] req0 = '0;
    logic [3:0] gnt0, done0;
    logic       busy0;
    logic [3:0] cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsm_count_arbiter #(.N_REQ(4), .CNT_W(4), .TERM(15)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
    );

    fsm_count_arbiter #(.N_REQ(4), .CNT_W(4), .TERM(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .done(done0), .busy(busy0), .cnt(cnt0)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one job at a time, tracked by cycles elapsed since grant.
    bit m_busy;
    int m_owner, m_el, m_ptr;

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_el    <= 0;
            m_ptr   <= 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_busy  <= 1'b1;
                m_owner <= first_from(req, m_ptr);
                m_el    <= 0;
            end
        end else if (m_el == TERM + 1 || !req[m_owner]) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_owner + 1) % N;
        end else begin
            m_el <= m_el + 1;
        end
    end

    task automatic tick();
        int unsigned eg, ed;
        @(negedge clk);
        eg = m_busy ? (32'd1 << m_owner) : 32'd0;
        ed = (m_busy && m_el == TERM + 1) ? (32'd1 << m_owner) : 32'd0;
        check("model_gnt", gnt, eg);
        check("model_done", done, ed);
        check("model_busy", busy, m_busy);
        if (m_busy) check("model_cnt", cnt, (m_el > TERM) ? TERM : m_el);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        req0 = '0;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        rst = 1'b0;
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    initial begin
        int order[$];
        int idle_runs[$];
        int idle, dones, guard;
        logic [3:0] prev_gnt;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Single request timing: edge 0 samples req=0100.
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check("t2_gnt", gnt, (c <= 17) ? 4'b0100 : 4'b0000);
            check("t2_done", done, (c == 17) ? 4'b0100 : 4'b0000);
            if (c <= 16) check("t2_cnt", cnt, c - 1);
            if (c == 18) check("t2_busy_low", busy, 0);
        end
        req = '0;
        tick();

        // All requesting: rotation order, one done per job, one idle cycle between jobs.
        do_reset();
        req = 4'b1111;
        prev_gnt = '0;
        idle = 0;
        dones = 0;
        guard = 0;
        while (order.size() < 5 && guard < 120) begin
            tick();
            guard++;
            if (gnt != 0 && prev_gnt == 0) begin
                if (order.size() > 0) idle_runs.push_back(idle);
                order.push_back(oh2i(gnt));
                idle = 0;
            end
            if (!busy) idle++;
            if (done != 0) dones++;
            prev_gnt = gnt;
        end
        check("t3_jobs", order.size(), 5);
        for (int k = 0; k < order.size(); k++) check("t3_order", order[k], exp_order[k]);
        foreach (idle_runs[k]) check("t3_idle_gap", idle_runs[k], 1);
        check("t3_dones", dones, 4);

        // Abort: drop req[1] while cnt==5.
        do_reset();
        req = 4'b0010;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(busy && cnt == 5) && guard < 40);
        check("t4_reach_cnt5", (busy && cnt == 5), 1);
        req = 4'b0000;
        tick();
        check("t4_gnt_off", gnt, 0);
        check("t4_busy_off", busy, 0);
        check("t4_no_done", done, 0);
        req = 4'b1111;
        tick();
        check("t4_next_gnt", gnt, 4'b0100);
        req = '0;
        repeat (20) tick();

        // Reset between edges mid-job: clears at once, ptr back to 0.
        do_reset();
        req = 4'b1000;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(busy && cnt == 7) && guard < 40);
        check("t5_reach_cnt7", (gnt == 4'b1000 && cnt == 7), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_gnt", gnt, 0);
        check("t5_async_done", done, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_cnt", cnt, 0);
        req = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t5_gnt_after_rst", gnt, 4'b0001);
        req = '0;
        repeat (20) tick();

        // TERM=0 instance: two cycles of grant, done on the second.
        do_reset();
        req0 = 4'b0001;
        @(negedge clk);
        check("t6_gnt_c1", gnt0, 4'b0001);
        check("t6_cnt_c1", cnt0, 0);
        check("t6_done_c1", done0, 0);
        @(negedge clk);
        check("t6_gnt_c2", gnt0, 4'b0001);
        check("t6_done_c2", done0, 4'b0001);
        req0 = '0;
        @(negedge clk);
        check("t6_gnt_c3", gnt0, 0);
        check("t6_busy_c3", busy0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(31) == 0) req[b] = ~req[b];
                if (done[b] && $urandom_range(3) == 0) req[b] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
